// File: rtl/prach_hb2_pair_sched.sv
// prach_hb2_pair_sched
// Front-end scheduler for the channelised half-band decimator. Each channel's
// even-frame sample is parked in a small pair memory. When the same channel's
// odd-frame sample arrives, the even/odd pair is emitted one clock later.
// The block also tracks frame alignment and flags sync and channel-order errors.

module prach_hb2_pair_sched #(
   parameter int NUM_CHANNEL      = 32,
   parameter int NUM_CHANNEL_USED = 24,
   parameter int WIDTH            = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din_dq,
   input  logic             din_dv,
   input  logic [7:0]       din_chn,
   input  logic             sync_in,
   output logic [WIDTH-1:0] dout_dp1,
   output logic [WIDTH-1:0] dout_dp2,
   output logic             dout_dv,
   output logic [7:0]       dout_chn,
   output logic             sync_out,
   output logic             locked,
   output logic             err_sync,
   output logic             err_order
);

   // A channel number is legal only if it is an active channel and also fits
   // in the TDM frame.
   localparam int CHN_LIMIT = (NUM_CHANNEL_USED < NUM_CHANNEL) ? NUM_CHANNEL_USED : NUM_CHANNEL;
   localparam int ADDR_W = (NUM_CHANNEL_USED > 1) ? $clog2(NUM_CHANNEL_USED) : 1;
   localparam logic [7:0] LAST_CHN  = 8'(NUM_CHANNEL_USED - 1);
   localparam logic [7:0] CHN_LIM8  = 8'(CHN_LIMIT);

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      EVEN = 2'd1,
      ODD  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        expChn_q, expChn_d;
   logic              memWe;
   logic              pairOut;
   logic              errSync_d;
   logic              errOrder_d;
   logic              chnInRange;
   logic [ADDR_W-1:0] memAddr;
   logic [WIDTH-1:0]  pairMem [NUM_CHANNEL_USED];

   assign chnInRange = (din_chn < CHN_LIM8);
   assign memAddr    = din_chn[ADDR_W-1:0];
   assign locked     = (state_q == EVEN) || (state_q == ODD);

   // Decide, for each valid sample, whether it is stored, paired or rejected,
   // and where the alignment tracker goes next. Idle cycles leave everything as is.
   always_comb begin
      state_d    = state_q;
      expChn_d   = expChn_q;
      memWe      = 1'b0;
      pairOut    = 1'b0;
      errSync_d  = 1'b0;
      errOrder_d = 1'b0;
      if (din_dv) begin
         case (state_q)
            HUNT: begin
               if (sync_in) begin
                  if (din_chn == 8'd0) begin
                     memWe    = 1'b1;
                     expChn_d = 8'd1;
                     state_d  = EVEN;
                  end else begin
                     errOrder_d = 1'b1;
                  end
               end
            end
            EVEN, ODD: begin
               if (sync_in) begin
                  if (din_chn == 8'd0) begin
                     if (!((state_q == EVEN) && (expChn_q == 8'd0))) begin
                        errSync_d = 1'b1;
                     end
                     memWe    = 1'b1;
                     expChn_d = 8'd1;
                     state_d  = EVEN;
                  end else begin
                     errSync_d  = 1'b1;
                     errOrder_d = 1'b1;
                     expChn_d   = 8'd0;
                     state_d    = HUNT;
                  end
               end else if ((din_chn != expChn_q) || !chnInRange) begin
                  errOrder_d = 1'b1;
                  expChn_d   = 8'd0;
                  state_d    = HUNT;
               end else begin
                  if (state_q == EVEN) begin
                     memWe = 1'b1;
                  end else begin
                     pairOut = 1'b1;
                  end
                  if (din_chn == LAST_CHN) begin
                     expChn_d = 8'd0;
                     state_d  = (state_q == EVEN) ? ODD : EVEN;
                  end else begin
                     expChn_d = expChn_q + 8'd1;
                  end
               end
            end
            default: begin
               expChn_d = 8'd0;
               state_d  = HUNT;
            end
         endcase
      end
   end

   // Pair memory holds the even-frame sample of each channel; it needs no reset
   // because it is always written before it is read.
   always_ff @(posedge clk) begin
      if (memWe) begin
         pairMem[memAddr] <= din_dq;
      end
   end

   // Alignment state and registered outputs; pair data holds between outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HUNT;
         expChn_q  <= 8'd0;
         dout_dp1  <= '0;
         dout_dp2  <= '0;
         dout_dv   <= 1'b0;
         dout_chn  <= 8'd0;
         sync_out  <= 1'b0;
         err_sync  <= 1'b0;
         err_order <= 1'b0;
      end else begin
         state_q   <= state_d;
         expChn_q  <= expChn_d;
         dout_dv   <= pairOut;
         sync_out  <= pairOut && (din_chn == 8'd0);
         err_sync  <= errSync_d;
         err_order <= errOrder_d;
         if (pairOut) begin
            dout_dp1 <= pairMem[memAddr];
            dout_dp2 <= din_dq;
            dout_chn <= din_chn;
         end
      end
   end

endmodule

// File: tb/tb_prach_hb2_pair_sched.sv
// tb_prach_hb2_pair_sched
// Scenario tasks drive the TDM stream; every expected pair is queued when its
// odd-frame sample is driven, and a monitor pops and compares each output.

module tb_prach_hb2_pair_sched;

   localparam int NCH = 24;

   typedef struct {
      logic [15:0] dp1;
      logic [15:0] dp2;
      logic [7:0]  chn;
      logic        sync;
      int          cycle;
   } pair_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] din_dq;
   logic        din_dv;
   logic [7:0]  din_chn;
   logic        sync_in;
   logic [15:0] dout_dp1;
   logic [15:0] dout_dp2;
   logic        dout_dv;
   logic [7:0]  dout_chn;
   logic        sync_out;
   logic        locked;
   logic        err_sync;
   logic        err_order;

   pair_t sb[$];
   int    testsRun = 0;
   int    failed = 0;
   int    cycleCnt = 0;
   int    outCnt = 0;
   int    errSyncCnt = 0;
   int    errOrderCnt = 0;

   prach_hb2_pair_sched #(
      .NUM_CHANNEL(32),
      .NUM_CHANNEL_USED(NCH),
      .WIDTH(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .din_dq(din_dq),
      .din_dv(din_dv),
      .din_chn(din_chn),
      .sync_in(sync_in),
      .dout_dp1(dout_dp1),
      .dout_dp2(dout_dp2),
      .dout_dv(dout_dv),
      .dout_chn(dout_chn),
      .sync_out(sync_out),
      .locked(locked),
      .err_sync(err_sync),
      .err_order(err_order)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to check the one-clock output latency
   always @(posedge clk) begin
      cycleCnt <= cycleCnt + 1;
   end

   // Scoreboard monitor: every output pair must match the queue head and land
   // on the cycle right after its odd-frame sample
   always @(negedge clk) begin
      pair_t e;
      if (err_sync) errSyncCnt++;
      if (err_order) errOrderCnt++;
      if (dout_dv) begin
         outCnt++;
         testsRun++;
         if (sb.size() == 0) begin
            failed++;
            $display("[TB] FAIL unexpected_out got chn=%0d dp1=%0d dp2=%0d, required no output",
                     dout_chn, dout_dp1, dout_dp2);
         end else begin
            e = sb.pop_front();
            if ({dout_dp1, dout_dp2, dout_chn, sync_out} !== {e.dp1, e.dp2, e.chn, e.sync}
                || cycleCnt != e.cycle) begin
               failed++;
               $display("[TB] FAIL pair_out got dp1=%0d dp2=%0d chn=%0d sync=%0b cyc=%0d, required dp1=%0d dp2=%0d chn=%0d sync=%0b cyc=%0d",
                        dout_dp1, dout_dp2, dout_chn, sync_out, cycleCnt,
                        e.dp1, e.dp2, e.chn, e.sync, e.cycle);
            end
         end
      end
   end

   // Drive one sample for one clock; optionally queue the pair it should produce
   task automatic sendSample(input int chn, input int dq, input bit sync,
                             input bit expectOut, input int dp1Exp);
      pair_t p;
      din_chn = 8'(chn);
      din_dq  = 16'(dq);
      sync_in = sync;
      din_dv  = 1'b1;
      if (expectOut) begin
         p.dp1   = 16'(dp1Exp);
         p.dp2   = 16'(dq);
         p.chn   = 8'(chn);
         p.sync  = (chn == 0);
         p.cycle = cycleCnt + 1;
         sb.push_back(p);
      end
      @(negedge clk);
      din_dv  = 1'b0;
      sync_in = 1'b0;
   endtask

   task automatic idle(input int n);
      din_dv  = 1'b0;
      sync_in = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic gap(input int maxGap);
      if (maxGap > 0) idle($urandom_range(maxGap, 1));
   endtask

   // Sync-aligned even frame followed by an odd frame that pairs with it
   task automatic sendFramePair(input int aBase, input int bBase, input int maxGap);
      for (int k = 0; k < NCH; k++) begin
         sendSample(k, aBase + k, k == 0, 1'b0, 0);
         gap(maxGap);
      end
      for (int k = 0; k < NCH; k++) begin
         sendSample(k, bBase + k, 1'b0, 1'b1, aBase + k);
         gap(maxGap);
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic checkDrained(input string name, input int outBase, input int outExp,
                               input int esBase, input int esExp,
                               input int eoBase, input int eoExp);
      idle(3);
      testsRun++;
      if (sb.size() != 0 || outCnt - outBase != outExp) begin
         failed++;
         $display("[TB] FAIL %s_outputs got %0d outputs (%0d pending), required %0d",
                  name, outCnt - outBase, sb.size(), outExp);
         sb.delete();
      end
      testsRun++;
      if (errSyncCnt - esBase != esExp || errOrderCnt - eoBase != eoExp) begin
         failed++;
         $display("[TB] FAIL %s_errors got sync=%0d order=%0d, required sync=%0d order=%0d",
                  name, errSyncCnt - esBase, errOrderCnt - eoBase, esExp, eoExp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #3;
      testsRun++;
      if ({dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, locked, err_sync, err_order} !== '0) begin
         failed++;
         $display("[TB] FAIL reset_outputs got dv=%0b chn=%0d lock=%0b es=%0b eo=%0b, required all 0",
                  dout_dv, dout_chn, locked, err_sync, err_order);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_clean();
      int o = outCnt, es = errSyncCnt, eo = errOrderCnt;
      sendSample(0, 100, 1'b1, 1'b0, 0);
      testsRun++;
      if (locked !== 1'b1) begin
         failed++;
         $display("[TB] FAIL clean_lock got %0b, required 1", locked);
      end
      for (int k = 1; k < NCH; k++) sendSample(k, 100 + k, 1'b0, 1'b0, 0);
      for (int k = 0; k < NCH; k++) sendSample(k, 200 + k, 1'b0, 1'b1, 100 + k);
      checkDrained("clean", o, NCH, es, 0, eo, 0);
      testsRun++;
      if (dout_dv !== 1'b0 || dout_chn !== 8'd23 || dout_dp2 !== 16'd223) begin
         failed++;
         $display("[TB] FAIL clean_hold got dv=%0b chn=%0d dp2=%0d, required dv=0 chn=23 dp2=223",
                  dout_dv, dout_chn, dout_dp2);
      end
   endtask

   task automatic test_unsynced();
      int o, es, eo;
      applyReset();
      o = outCnt; es = errSyncCnt; eo = errOrderCnt;
      for (int k = 0; k < 30; k++) sendSample(k % NCH, 50 + k, 1'b0, 1'b0, 0);
      testsRun++;
      if (locked !== 1'b0 || outCnt != o) begin
         failed++;
         $display("[TB] FAIL unsynced_hunt got lock=%0b outputs=%0d, required lock=0 outputs=0",
                  locked, outCnt - o);
      end
      sendFramePair(1000, 2000, 0);
      checkDrained("unsynced", o, NCH, es, 0, eo, 0);
   endtask

   task automatic test_order_error();
      int o = outCnt, es = errSyncCnt, eo = errOrderCnt;
      for (int k = 0; k < NCH; k++) sendSample(k, 3000 + k, k == 0, 1'b0, 0);
      for (int k = 0; k < 4; k++) sendSample(k, 4000 + k, 1'b0, 1'b1, 3000 + k);
      sendSample(5, 4005, 1'b0, 1'b0, 0);
      testsRun++;
      if (err_order !== 1'b1 || err_sync !== 1'b0 || dout_dv !== 1'b0 || locked !== 1'b0) begin
         failed++;
         $display("[TB] FAIL order_pulse got eo=%0b es=%0b dv=%0b lock=%0b, required eo=1 es=0 dv=0 lock=0",
                  err_order, err_sync, dout_dv, locked);
      end
      for (int k = 6; k < 11; k++) sendSample(k, 4000 + k, 1'b0, 1'b0, 0);
      sendFramePair(5000, 6000, 0);
      checkDrained("order", o, 4 + NCH, es, 0, eo, 1);
   endtask

   task automatic test_mid_sync();
      int o = outCnt, es = errSyncCnt, eo = errOrderCnt;
      for (int k = 0; k < 10; k++) sendSample(k, 300 + k, k == 0, 1'b0, 0);
      sendSample(0, 400, 1'b1, 1'b0, 0);
      testsRun++;
      if (err_sync !== 1'b1 || err_order !== 1'b0 || locked !== 1'b1) begin
         failed++;
         $display("[TB] FAIL midsync_pulse got es=%0b eo=%0b lock=%0b, required es=1 eo=0 lock=1",
                  err_sync, err_order, locked);
      end
      for (int k = 1; k < NCH; k++) sendSample(k, 400 + k, 1'b0, 1'b0, 0);
      for (int k = 0; k < NCH; k++) sendSample(k, 500 + k, 1'b0, 1'b1, 400 + k);
      checkDrained("midsync", o, NCH, es, 1, eo, 0);
   endtask

   task automatic test_gaps_range();
      int o = outCnt, es = errSyncCnt, eo = errOrderCnt;
      sendFramePair(700, 800, 5);
      sendSample(0, 900, 1'b1, 1'b0, 0);
      sendSample(1, 901, 1'b0, 1'b0, 0);
      sendSample(2, 902, 1'b0, 1'b0, 0);
      sendSample(24, 924, 1'b0, 1'b0, 0);
      testsRun++;
      if (err_order !== 1'b1 || locked !== 1'b0) begin
         failed++;
         $display("[TB] FAIL range_pulse got eo=%0b lock=%0b, required eo=1 lock=0",
                  err_order, locked);
      end
      checkDrained("gaps", o, NCH, es, 0, eo, 1);
   endtask

   task automatic test_async_reset();
      int o, es, eo;
      applyReset();
      o = outCnt; es = errSyncCnt; eo = errOrderCnt;
      for (int k = 0; k < NCH; k++) sendSample(k, 1100 + k, k == 0, 1'b0, 0);
      for (int k = 0; k < 12; k++) sendSample(k, 1200 + k, 1'b0, 1'b1, 1100 + k);
      din_chn = 8'd12;
      din_dq  = 16'd1212;
      din_dv  = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      testsRun++;
      if ({dout_dp1, dout_dp2, dout_dv, dout_chn, sync_out, locked, err_sync, err_order} !== '0) begin
         failed++;
         $display("[TB] FAIL async_reset got dv=%0b chn=%0d dp1=%0d lock=%0b, required all 0",
                  dout_dv, dout_chn, dout_dp1, locked);
      end
      din_dv = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sendFramePair(1300, 1400, 2);
      checkDrained("rst_resume", o, 12 + NCH, es, 0, eo, 0);
   endtask

   // Scenario sequence
   initial begin
      rst_n   = 1'b1;
      din_dq  = '0;
      din_dv  = 1'b0;
      din_chn = '0;
      sync_in = 1'b0;
      test_reset();
      test_clean();
      test_unsynced();
      test_order_error();
      test_mid_sync();
      test_gaps_range();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", testsRun, failed);
      $finish;
   end

endmodule
